noc_traffic_gen_node: RTL and testbench

//  Parametrised NoC endpoint: packet generator plus self-checking sink on one router local port.
//  TX: NUM_PKTS packets of PKT_LEN flits to (DEST_X_ID,DEST_Y_ID), INJECT_GAP idle cycles apart.
//  RX: checks header dest, payload pattern and length; counts good packets and errors.

---
 rtl/noc_traffic_gen_node_if.sv | 29 ++
 rtl/noc_traffic_gen_node.sv | 265 ++++++++++++++++++++++++++
 tb/tb_noc_traffic_gen_node.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_traffic_gen_node_if.sv
// Router local-port bundle for one NoC endpoint.
// master: the endpoint (drives sender_* and receive_ready).
// slave : the router side (drives receive_* and sender_ready).
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_traffic_gen_node_if;
   logic                       receive_valid;
   logic                       receive_ready;
   logic [`Noc_Data_Width-1:0] receive_flit;
   logic                       receive_is_header;
   logic                       receive_is_tail;
   logic                       sender_valid;
   logic                       sender_ready;
   logic [`Noc_Data_Width-1:0] sender_flit;
   logic                       sender_is_header;
   logic                       sender_is_tail;

   modport master (
      input  receive_valid, receive_flit, receive_is_header, receive_is_tail, sender_ready,
      output receive_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
   );

   modport slave (
      output receive_valid, receive_flit, receive_is_header, receive_is_tail, sender_ready,
      input  receive_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
   );
endinterface

// File: rtl/noc_traffic_gen_node.sv
// NoC traffic generator / self-checking sink for one router local port.
// TX sends NUM_PKTS packets (0 = endless) of PKT_LEN flits to (DEST_X_ID, DEST_Y_ID).
// RX checks destination, payload pattern and length, counting good packets and errors.
// Optional feature macro NOC_TG_RAND_BACKPRESSURE_EN: LFSR-driven receive_ready stalls.
//
// TX FSM states:
//   state  | meaning
//   S_IDLE | no flit offered; leaves when gen_en && !tx_done
//   S_HEAD | header flit offered on sender_*
//   S_BODY | payload flit idx_q offered
//   S_GAP  | idle cycles after a tail before the next header
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_traffic_gen_node #(
   parameter int X_ID       = 0,
   parameter int Y_ID       = 0,
   parameter int DEST_X_ID  = 1,
   parameter int DEST_Y_ID  = 1,
   parameter int COORD_W    = 4,
   parameter int PKT_LEN    = 4,
   parameter int NUM_PKTS   = 8,
   parameter int INJECT_GAP = 2,
   parameter int CNT_W      = 8
) (
   input  logic                   noc_clk,
   input  logic                   noc_rst_n,
   input  logic                   gen_en,
   noc_traffic_gen_node_if.master noc_port,
   output logic [CNT_W-1:0]       sent_num,
   output logic [CNT_W-1:0]       receive_num,
   output logic [CNT_W-1:0]       error_num,
   output logic                   tx_done
);

   localparam int DW = `Noc_Data_Width;
   localparam int C  = COORD_W;
   localparam logic [C-1:0]  X_C      = C'(X_ID);
   localparam logic [C-1:0]  Y_C      = C'(Y_ID);
   localparam logic [C-1:0]  DEST_X_C = C'(DEST_X_ID);
   localparam logic [C-1:0]  DEST_Y_C = C'(DEST_Y_ID);
   localparam logic [7:0]    LEN_C    = 8'(PKT_LEN);
   localparam logic [7:0]    LAST_IDX = 8'(PKT_LEN - 1);
   localparam logic [15:0]   GAP_C    = 16'(INJECT_GAP);
   localparam int            PKT_CNT_W = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
   localparam logic [PKT_CNT_W-1:0] LAST_PKT = PKT_CNT_W'(NUM_PKTS - 1);

   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_GAP} tx_state_e;

   tx_state_e               state_q, state_d;
   logic [7:0]              seq_q, seq_d;
   logic [7:0]              idx_q, idx_d;
   logic [15:0]             gap_q, gap_d;
   logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic                    tx_done_q, tx_done_d;
   logic [CNT_W-1:0]        sent_q, sent_d;
   logic                    tx_valid, tx_head, tx_tail, tx_fire;
   logic [DW-1:0]           tx_flit;

   logic                    rx_ready, rx_fire;
   logic                    rx_act_q, rx_act_d;
   logic                    rx_err_q, rx_err_d;
   logic [7:0]              rx_seq_q, rx_seq_d;
   logic [7:0]              rx_idx_q, rx_idx_d;
   logic [7:0]              rx_len_q, rx_len_d;
   logic [CNT_W-1:0]        recv_q, recv_d;
   logic [CNT_W-1:0]        err_q, err_d;
   logic [1:0]              err_inc;
   logic [CNT_W:0]          err_sum;
   logic                    hdr_bad, pay_bad, len_bad, pkt_bad;
   logic [DW-1:0]           rx_exp;

   // TX next-state, flit formatting and packet bookkeeping
   always_comb begin
      state_d   = state_q;
      seq_d     = seq_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      pkt_cnt_d = pkt_cnt_q;
      tx_done_d = tx_done_q;
      sent_d    = sent_q;
      tx_valid  = 1'b0;
      tx_head   = 1'b0;
      tx_tail   = 1'b0;
      tx_flit   = '0;
      case (state_q)
         S_IDLE: if (gen_en && !tx_done_q) state_d = S_HEAD;
         S_HEAD: begin
            tx_valid = 1'b1;
            tx_head  = 1'b1;
            tx_tail  = (PKT_LEN == 1);
            tx_flit[C-1:0]           = DEST_Y_C;
            tx_flit[2*C-1:C]         = DEST_X_C;
            tx_flit[3*C-1:2*C]       = Y_C;
            tx_flit[4*C-1:3*C]       = X_C;
            tx_flit[4*C+7:4*C]       = seq_q;
            tx_flit[4*C+15:4*C+8]    = LEN_C;
         end
         S_BODY: begin
            tx_valid       = 1'b1;
            tx_tail        = (idx_q == LAST_IDX);
            tx_flit[15:0]  = {seq_q, idx_q};
         end
         S_GAP: begin
            if (gap_q == 16'd1) state_d = S_IDLE;
            else                gap_d   = gap_q - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase

      tx_fire = tx_valid && noc_port.sender_ready;

      if (tx_fire && !tx_tail) begin
         state_d = S_BODY;
         idx_d   = (state_q == S_HEAD) ? 8'd1 : idx_q + 8'd1;
      end

      if (tx_fire && tx_tail) begin
         seq_d  = seq_q + 8'd1;
         sent_d = sent_q + 1'b1;
         if (NUM_PKTS != 0) begin
            if (pkt_cnt_q == LAST_PKT) tx_done_d = 1'b1;
            else                       pkt_cnt_d = pkt_cnt_q + 1'b1;
         end
         // GAP and IDLE both count as idle cycles, so short gaps skip states
         if (INJECT_GAP >= 2) begin
            state_d = S_GAP;
            gap_d   = GAP_C - 16'd1;
         end else if (INJECT_GAP == 1) begin
            state_d = S_IDLE;
         end else if (gen_en && !tx_done_d) begin
            state_d = S_HEAD;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // TX state register
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state_q   <= S_IDLE;
         seq_q     <= '0;
         idx_q     <= '0;
         gap_q     <= '0;
         pkt_cnt_q <= '0;
         tx_done_q <= 1'b0;
         sent_q    <= '0;
      end else begin
         state_q   <= state_d;
         seq_q     <= seq_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         pkt_cnt_q <= pkt_cnt_d;
         tx_done_q <= tx_done_d;
         sent_q    <= sent_d;
      end
   end

   // RX checker: first error in a packet is counted once, rest of packet discarded
   always_comb begin
      rx_act_d = rx_act_q;
      rx_err_d = rx_err_q;
      rx_seq_d = rx_seq_q;
      rx_idx_d = rx_idx_q;
      rx_len_d = rx_len_q;
      recv_d   = recv_q;
      err_inc  = 2'd0;
      hdr_bad  = 1'b0;
      pay_bad  = 1'b0;
      len_bad  = 1'b0;
      pkt_bad  = 1'b0;
      rx_exp   = '0;
      rx_fire  = noc_port.receive_valid && rx_ready;
      if (rx_fire) begin
         if (noc_port.receive_is_header) begin
            if (rx_act_q && !rx_err_q) err_inc = err_inc + 2'd1;
            hdr_bad = (noc_port.receive_flit[2*C-1:C] != X_C) ||
                      (noc_port.receive_flit[C-1:0] != Y_C);
            if (noc_port.receive_is_tail)
               len_bad = (noc_port.receive_flit[4*C+15:4*C+8] != 8'd1);
            pkt_bad = hdr_bad || len_bad;
            if (pkt_bad) err_inc = err_inc + 2'd1;
            rx_seq_d = noc_port.receive_flit[4*C+7:4*C];
            rx_len_d = noc_port.receive_flit[4*C+15:4*C+8];
            rx_idx_d = 8'd1;
            rx_act_d = !noc_port.receive_is_tail;
            rx_err_d = pkt_bad;
            if (noc_port.receive_is_tail && !pkt_bad) recv_d = recv_q + 1'b1;
         end else if (!rx_act_q) begin
            // orphan flits open a discarded pseudo-packet so the run counts once
            err_inc  = 2'd1;
            rx_act_d = !noc_port.receive_is_tail;
            rx_err_d = 1'b1;
         end else begin
            rx_exp[15:0] = {rx_seq_q, rx_idx_q};
            pay_bad = (noc_port.receive_flit != rx_exp);
            if (noc_port.receive_is_tail) len_bad = ((rx_idx_q + 8'd1) != rx_len_q);
            pkt_bad = rx_err_q || pay_bad || len_bad;
            if (!rx_err_q && (pay_bad || len_bad)) err_inc = 2'd1;
            rx_err_d = pkt_bad;
            rx_idx_d = rx_idx_q + 8'd1;
            if (noc_port.receive_is_tail) begin
               rx_act_d = 1'b0;
               if (!pkt_bad) recv_d = recv_q + 1'b1;
            end
         end
      end
      err_sum = {1'b0, err_q} + (CNT_W+1)'(err_inc);
      err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
   end

   // RX state and status counters
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         rx_act_q <= 1'b0;
         rx_err_q <= 1'b0;
         rx_seq_q <= '0;
         rx_idx_q <= '0;
         rx_len_q <= '0;
         recv_q   <= '0;
         err_q    <= '0;
      end else begin
         rx_act_q <= rx_act_d;
         rx_err_q <= rx_err_d;
         rx_seq_q <= rx_seq_d;
         rx_idx_q <= rx_idx_d;
         rx_len_q <= rx_len_d;
         recv_q   <= recv_d;
         err_q    <= err_d;
      end
   end

`ifdef NOC_TG_RAND_BACKPRESSURE_EN
   localparam logic [15:0] LFSR_SEED = 16'({X_C, Y_C}) | 16'd1;
   logic [15:0] lfsr_q, lfsr_d;

   // x^16+x^14+x^13+x^11+1 Fibonacci LFSR
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // LFSR register, free-running every cycle
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) lfsr_q <= LFSR_SEED;
      else            lfsr_q <= lfsr_d;
   end

   assign rx_ready = ~lfsr_q[0];
`else
   assign rx_ready = 1'b1;
`endif

   assign noc_port.receive_ready    = rx_ready;
   assign noc_port.sender_valid     = tx_valid;
   assign noc_port.sender_flit      = tx_flit;
   assign noc_port.sender_is_header = tx_head;
   assign noc_port.sender_is_tail   = tx_tail;
   assign sent_num    = sent_q;
   assign receive_num = recv_q;
   assign error_num   = err_q;
   assign tx_done     = tx_done_q;

endmodule

// File: tb/tb_noc_traffic_gen_node.sv
// Directed bench: node A (PKT_LEN=4, NUM_PKTS=3, GAP=2) in loopback or with injected
// RX flits; node B (PKT_LEN=1, NUM_PKTS=300, GAP=0) for seq/sent_num wrap.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_traffic_gen_node;
   localparam int DW = `Noc_Data_Width;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          gen_en_a, gen_en_b;
   logic          loopback, tb_sready;
   logic          inj_valid, inj_head, inj_tail;
   logic [DW-1:0] inj_flit;
   logic [7:0]    sent_a, recv_a, err_a, sent_b, recv_b, err_b;
   logic          done_a, done_b;
   int            checks = 0;
   int            errors = 0;

   noc_traffic_gen_node_if ifa();
   noc_traffic_gen_node_if ifb();

   assign ifa.sender_ready      = tb_sready;
   assign ifa.receive_valid     = loopback ? (ifa.sender_valid & tb_sready) : inj_valid;
   assign ifa.receive_flit      = loopback ? ifa.sender_flit : inj_flit;
   assign ifa.receive_is_header = loopback ? ifa.sender_is_header : inj_head;
   assign ifa.receive_is_tail   = loopback ? ifa.sender_is_tail : inj_tail;

   assign ifb.sender_ready      = 1'b1;
   assign ifb.receive_valid     = 1'b0;
   assign ifb.receive_flit      = '0;
   assign ifb.receive_is_header = 1'b0;
   assign ifb.receive_is_tail   = 1'b0;

   noc_traffic_gen_node #(
      .X_ID(1), .Y_ID(2), .DEST_X_ID(1), .DEST_Y_ID(2), .COORD_W(4),
      .PKT_LEN(4), .NUM_PKTS(3), .INJECT_GAP(2), .CNT_W(8)
   ) u_a (
      .noc_clk(clk), .noc_rst_n(rst_n), .gen_en(gen_en_a), .noc_port(ifa),
      .sent_num(sent_a), .receive_num(recv_a), .error_num(err_a), .tx_done(done_a)
   );

   noc_traffic_gen_node #(
      .X_ID(0), .Y_ID(0), .DEST_X_ID(1), .DEST_Y_ID(1), .COORD_W(4),
      .PKT_LEN(1), .NUM_PKTS(300), .INJECT_GAP(0), .CNT_W(8)
   ) u_b (
      .noc_clk(clk), .noc_rst_n(rst_n), .gen_en(gen_en_b), .noc_port(ifb),
      .sent_num(sent_b), .receive_num(recv_b), .error_num(err_b), .tx_done(done_b)
   );

   function automatic logic [DW-1:0] hdr_a(input logic [7:0] s);
      logic [DW-1:0] r;
      r = '0;
      r[31:0] = {8'd4, s, 16'h1212};
      return r;
   endfunction

   function automatic logic [DW-1:0] hdr_b(input logic [7:0] s);
      logic [DW-1:0] r;
      r = '0;
      r[31:0] = {8'd1, s, 16'h0011};
      return r;
   endfunction

   function automatic logic [DW-1:0] pay(input logic [7:0] s, input logic [7:0] k);
      logic [DW-1:0] r;
      r = '0;
      r[15:0] = {s, k};
      return r;
   endfunction

   function automatic logic [DW-1:0] w(input logic [31:0] v);
      logic [DW-1:0] r;
      r = '0;
      r[31:0] = v;
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic inject(input logic [DW-1:0] f, input logic h, input logic t);
      inj_valid = 1'b1;
      inj_flit  = f;
      inj_head  = h;
      inj_tail  = t;
      @(negedge clk);
      inj_valid = 1'b0;
      inj_head  = 1'b0;
      inj_tail  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifa.sender_valid, ifa.sender_is_header, ifa.sender_is_tail, done_a} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_a_flags: got %b expected 0000",
                  {ifa.sender_valid, ifa.sender_is_header, ifa.sender_is_tail, done_a});
      end
      checks++;
      if ({sent_a, recv_a, err_a} !== 24'h0) begin
         errors++;
         $display("FAIL reset_a_counters: got %h expected 000000", {sent_a, recv_a, err_a});
      end
      checks++;
      if (ifa.sender_flit !== '0) begin
         errors++;
         $display("FAIL reset_a_flit: got %h expected 0", ifa.sender_flit);
      end
      checks++;
      if (ifa.receive_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_rx_ready: got %b expected 1", ifa.receive_ready);
      end
      checks++;
      if ({ifb.sender_valid, done_b, sent_b, recv_b, err_b} !== 26'h0) begin
         errors++;
         $display("FAIL reset_b: got %h expected 0", {ifb.sender_valid, done_b, sent_b, recv_b, err_b});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loopback();
      int nflit = 0;
      int idle  = 0;
      int pkt, k;
      logic [DW-1:0] exp_f;
      loopback  = 1'b1;
      tb_sready = 1'b1;
      gen_en_a  = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         if (ifa.sender_valid && ifa.sender_ready) begin
            pkt = nflit / 4;
            k   = nflit % 4;
            exp_f = (k == 0) ? hdr_a(8'(pkt)) : pay(8'(pkt), 8'(k));
            checks++;
            if (nflit >= 12) begin
               errors++;
               $display("FAIL loop_extra_flit: got flit #%0d expected at most 12", nflit + 1);
            end
            checks++;
            if ({ifa.sender_flit, ifa.sender_is_header, ifa.sender_is_tail} !== {exp_f, k == 0, k == 3}) begin
               errors++;
               $display("FAIL loop_flit%0d: got %h/%b%b expected %h/%b%b", nflit, ifa.sender_flit,
                        ifa.sender_is_header, ifa.sender_is_tail, exp_f, k == 0, k == 3);
            end
            if (k == 0 && pkt > 0) begin
               checks++;
               if (idle != 2) begin
                  errors++;
                  $display("FAIL loop_gap_pkt%0d: got %0d idle cycles expected 2", pkt, idle);
               end
            end
            idle = 0;
            nflit++;
         end else if (nflit > 0) begin
            idle++;
         end
      end
      checks++;
      if (nflit != 12) begin
         errors++;
         $display("FAIL loop_flit_count: got %0d expected 12", nflit);
      end
      checks++;
      if ({sent_a, recv_a, err_a, done_a} !== {8'd3, 8'd3, 8'd0, 1'b1}) begin
         errors++;
         $display("FAIL loop_status: got sent=%0d recv=%0d err=%0d done=%b expected 3 3 0 1",
                  sent_a, recv_a, err_a, done_a);
      end
   endtask

   task automatic test_backpressure();
      bit found = 0;
      do_reset();
      loopback  = 1'b1;
      tb_sready = 1'b1;
      gen_en_a  = 1'b1;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         @(negedge clk);
         if (ifa.sender_valid && !ifa.sender_is_header) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL bp_body_timeout: got no body flit expected one within 40 cycles");
      end
      @(negedge clk);
      tb_sready = 1'b0;
      gen_en_a  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({ifa.sender_valid, ifa.sender_flit, ifa.sender_is_header, ifa.sender_is_tail} !==
             {1'b1, pay(8'd0, 8'd2), 2'b00}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b %h %b%b expected v=1 %h 00", i, ifa.sender_valid,
                     ifa.sender_flit, ifa.sender_is_header, ifa.sender_is_tail, pay(8'd0, 8'd2));
         end
      end
      tb_sready = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if ({sent_a, recv_a, err_a, done_a, ifa.sender_valid} !== {8'd1, 8'd1, 8'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL bp_status: got sent=%0d recv=%0d err=%0d done=%b v=%b expected 1 1 0 0 0",
                  sent_a, recv_a, err_a, done_a, ifa.sender_valid);
      end
   endtask

   task automatic test_reset_mid_body();
      bit found = 0;
      gen_en_a = 1'b1;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         @(negedge clk);
         if (ifa.sender_valid && !ifa.sender_is_header) found = 1;
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (!found || {ifa.sender_valid, ifa.sender_is_header, ifa.sender_is_tail, done_a} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_mid_flags: got found=%b flags=%b expected found=1 flags=0000", found,
                  {ifa.sender_valid, ifa.sender_is_header, ifa.sender_is_tail, done_a});
      end
      checks++;
      if ({ifa.sender_flit, sent_a, recv_a, err_a} !== {{DW{1'b0}}, 24'h0}) begin
         errors++;
         $display("FAIL rst_mid_values: got flit=%h sent=%0d recv=%0d err=%0d expected all 0",
                  ifa.sender_flit, sent_a, recv_a, err_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      found = 0;
      for (int cyc = 0; cyc < 20 && !found; cyc++) begin
         @(negedge clk);
         if (ifa.sender_valid) found = 1;
      end
      checks++;
      if (!found || ifa.sender_flit !== hdr_a(8'd0) || ifa.sender_is_header !== 1'b1) begin
         errors++;
         $display("FAIL rst_restart_hdr: got found=%b %h expected header %h", found,
                  ifa.sender_flit, hdr_a(8'd0));
      end
      gen_en_a = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if ({sent_a, recv_a, err_a} !== {8'd1, 8'd1, 8'd0}) begin
         errors++;
         $display("FAIL rst_restart_status: got sent=%0d recv=%0d err=%0d expected 1 1 0",
                  sent_a, recv_a, err_a);
      end
   endtask

   task automatic test_rx_errors();
      loopback = 1'b0;
      do_reset();
      inject(pay(8'd0, 8'd1), 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if ({err_a, recv_a} !== {8'd1, 8'd0}) begin
         errors++;
         $display("FAIL rx_orphan_body: got err=%0d recv=%0d expected 1 0", err_a, recv_a);
      end
      inject(w(32'h0405_0012), 1'b1, 1'b0);
      inject(w(32'h0000_0501), 1'b0, 1'b0);
      inject(w(32'h0000_0502), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if ({err_a, recv_a} !== {8'd2, 8'd0}) begin
         errors++;
         $display("FAIL rx_short_tail: got err=%0d recv=%0d expected 2 0", err_a, recv_a);
      end
      inject(w(32'h0406_0012), 1'b1, 1'b0);
      inject(w(32'h0000_0601), 1'b0, 1'b0);
      inject(w(32'h0000_0602), 1'b0, 1'b0);
      inject(w(32'h0000_0603), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if ({err_a, recv_a} !== {8'd2, 8'd1}) begin
         errors++;
         $display("FAIL rx_good_after_bad: got err=%0d recv=%0d expected 2 1", err_a, recv_a);
      end
      inject(w(32'h0100_0033), 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({err_a, recv_a} !== {8'd3, 8'd1}) begin
         errors++;
         $display("FAIL rx_bad_dest: got err=%0d recv=%0d expected 3 1", err_a, recv_a);
      end
      inject(w(32'h0207_0012), 1'b1, 1'b0);
      inject(w(32'h0000_0799), 1'b0, 1'b1);
      inject(w(32'h0108_0012), 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({err_a, recv_a} !== {8'd4, 8'd2}) begin
         errors++;
         $display("FAIL rx_bad_payload_single_ok: got err=%0d recv=%0d expected 4 2", err_a, recv_a);
      end
      inject(w(32'h0209_0012), 1'b1, 1'b0);
      inject(w(32'h020A_0012), 1'b1, 1'b0);
      inject(w(32'h0000_0A01), 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if ({err_a, recv_a} !== {8'd5, 8'd3}) begin
         errors++;
         $display("FAIL rx_header_restart: got err=%0d recv=%0d expected 5 3", err_a, recv_a);
      end
   endtask

   task automatic test_single_flit_wrap();
      int n = 0;
      gen_en_b = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (ifb.sender_valid) begin
            checks++;
            if (n >= 300 || {ifb.sender_flit, ifb.sender_is_header, ifb.sender_is_tail} !==
                {hdr_b(8'(n)), 2'b11}) begin
               errors++;
               $display("FAIL wrap_flit%0d: got %h/%b%b expected %h/11", n, ifb.sender_flit,
                        ifb.sender_is_header, ifb.sender_is_tail, hdr_b(8'(n)));
            end
            n++;
         end
      end
      checks++;
      if (n != 300) begin
         errors++;
         $display("FAIL wrap_count: got %0d flits expected 300", n);
      end
      checks++;
      if ({sent_b, done_b, recv_b, err_b} !== {8'd44, 1'b1, 8'd0, 8'd0}) begin
         errors++;
         $display("FAIL wrap_status: got sent=%0d done=%b recv=%0d err=%0d expected 44 1 0 0",
                  sent_b, done_b, recv_b, err_b);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      gen_en_a  = 1'b0;
      gen_en_b  = 1'b0;
      loopback  = 1'b0;
      tb_sready = 1'b1;
      inj_valid = 1'b0;
      inj_head  = 1'b0;
      inj_tail  = 1'b0;
      inj_flit  = '0;
      test_reset();
      test_loopback();
      test_backpressure();
      test_reset_mid_body();
      test_rx_errors();
      test_single_flit_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
